register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 32, register and data-path width in bits.
REQ-002 Parameter NREG, default 4, number of general registers and, separately, number of scratch registers.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 I  input  WIDTH  write data, typically the ALU result fed back.
REQ-006 RegSel  input  NREG  one enable bit per general register; bit 3 = R1 down to bit 0 = R4.
REQ-007 ScrSel  input  NREG  one enable bit per scratch register; bit 3 = S1 down to bit 0 = S4.
REQ-008 FunSel  input  3  operation code, shared by all enabled registers.
REQ-009 OutASel  input  3  ALU operand A source select.
REQ-010 OutBSel  input  3  ALU operand B source select.
REQ-011 OutA  output  WIDTH  operand A, drives ALU input A.
REQ-012 OutB  output  WIDTH  operand B, drives ALU input B.

Function
REQ-013 Block SHALL hold 8 registers of WIDTH bits: R1..R4 and S1..S4.
REQ-014 A register SHALL update only on a rising Clock edge, and only when its RegSel or ScrSel bit is 1; every other register SHALL hold its value.
REQ-015 FunSel 000 SHALL hold the register unchanged, even when it is enabled.
REQ-016 FunSel 001 SHALL load I.
REQ-017 FunSel 010 SHALL clear the register to 0.
REQ-018 FunSel 011 SHALL increment by 1 modulo 2^WIDTH; all-ones SHALL wrap to 0.
REQ-019 FunSel 100 SHALL decrement by 1 modulo 2^WIDTH; 0 SHALL wrap to all-ones.
REQ-020 FunSel 101 SHALL load I[15:0] zero-extended to WIDTH.
REQ-021 FunSel 110 SHALL load I[15:0] sign-extended from bit 15.
REQ-022 FunSel 111 SHALL write I[7:0] into bits [7:0] and keep bits [WIDTH-1:8].
REQ-023 Several enable bits set at once SHALL apply the same FunSel to every enabled register in the same cycle.
REQ-024 OutASel/OutBSel encoding SHALL be: 000 R1, 001 R2, 010 R3, 011 R4, 100 S1, 101 S2, 110 S3, 111 S4.
REQ-025 OutA and OutB SHALL be combinational from current register contents; zero read latency.
REQ-026 Read of a register being written in the same cycle SHALL return the pre-edge value; the new value appears after the edge, with no bypass.
REQ-027 OutASel may equal OutBSel; both outputs SHALL then carry the same value.
REQ-028 The per-register next-state logic SHALL contain no combinational path from OutA/OutB back to I, so an ALU feedback loop stays register-broken.

Reset
REQ-029 Reset low SHALL clear all 8 registers to 0 immediately, without waiting for a Clock edge; OutA and OutB then read 0.
REQ-030 Reset asserted mid-operation SHALL override any enabled FunSel.
REQ-031 While Reset is low, no register SHALL change on Clock edges.
REQ-032 The first Clock edge after Reset deasserts SHALL perform the normal operation.

Structure
REQ-033 The FunSel codes (3-bit) and OutSel codes SHALL be named constants in the shared CPU package, also used by the control unit.
REQ-034 One sub-module, register32, SHALL implement a single enabled register with the FunSel decode and async active-low reset; register_file SHALL instantiate it 8 times and add two 8:1 output muxes.

Verification
REQ-035 Reset low, then high; OutASel=000, OutBSel=111 -> OutA=0, OutB=0.
REQ-036 I=0x1234ABCD, RegSel=1000, FunSel=001, one edge; OutASel=000 -> OutA=0x1234ABCD; other registers still 0.
REQ-037 Load R2=0xFFFFFFFF, then FunSel=011 -> R2=0x00000000; then FunSel=100 -> R2=0xFFFFFFFF.
REQ-038 I=0x00008001; FunSel=110 on S1 -> 0xFFFF8001; FunSel=101 on S2 -> 0x00008001; R3=0xAABBCCDD then FunSel=111 with I=0x11 -> 0xAABBCC11.
REQ-039 RegSel=1111, ScrSel=1111, FunSel=010 after loading all eight -> every output select reads 0; FunSel=000 with all enabled -> values unchanged.
REQ-040 Reset pulled low between edges while R1=5 is incrementing -> OutA=0 before the next edge; no increment while Reset is low; first edge after release with FunSel=011 -> R1=1.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared CPU constants: register-file operation codes and operand-select codes.
// Latency: none (constants only).
// Backpressure: none.
package register_file_pkg;

   localparam int FUN_W = 3;
   localparam int SEL_W = 3;

   // Operation applied to every enabled register on a clock edge.
   typedef enum logic [FUN_W-1:0] {
      FUN_HOLD    = 3'b000,
      FUN_LOAD    = 3'b001,
      FUN_CLEAR   = 3'b010,
      FUN_INC     = 3'b011,
      FUN_DEC     = 3'b100,
      FUN_LOAD_ZX = 3'b101,
      FUN_LOAD_SX = 3'b110,
      FUN_LOAD_LB = 3'b111
   } fun_sel_e;

   // Operand source select for OutA/OutB.
   typedef enum logic [SEL_W-1:0] {
      SEL_R1 = 3'b000,
      SEL_R2 = 3'b001,
      SEL_R3 = 3'b010,
      SEL_R4 = 3'b011,
      SEL_S1 = 3'b100,
      SEL_S2 = 3'b101,
      SEL_S3 = 3'b110,
      SEL_S4 = 3'b111
   } out_sel_e;

endpackage

// File: rtl/register_file_if.sv
// Control/data bundle between the control unit (master) and the register file (slave).
// Latency: wires only.
// Backpressure: none; the register file accepts an operation every cycle.
interface register_file_if
   import register_file_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREG  = 4
);
   logic [WIDTH-1:0] I;
   logic [NREG-1:0]  RegSel;
   logic [NREG-1:0]  ScrSel;
   logic [FUN_W-1:0] FunSel;
   logic [SEL_W-1:0] OutASel;
   logic [SEL_W-1:0] OutBSel;
   logic [WIDTH-1:0] OutA;
   logic [WIDTH-1:0] OutB;

   modport master (
      output I, RegSel, ScrSel, FunSel, OutASel, OutBSel,
      input  OutA, OutB
   );

   modport slave (
      input  I, RegSel, ScrSel, FunSel, OutASel, OutBSel,
      output OutA, OutB
   );
endinterface

// File: rtl/register_file_register32.sv
// Single enabled register with FunSel decode (hold/load/clear/inc/dec/zx/sx/low-byte).
// Latency: new value visible one Clock edge after enable; output is the flop itself.
// Backpressure: none; asynchronous active-low Reset clears immediately.
module register32
   import register_file_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             En,
   input  logic [FUN_W-1:0] FunSel,
   input  logic [WIDTH-1:0] I,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] d;

   // Next value depends only on I and this register's own contents, never on OutA/OutB.
   always_comb begin
      d = Q;
      if (En) begin
         case (fun_sel_e'(FunSel))
            FUN_HOLD:    d = Q;
            FUN_LOAD:    d = I;
            FUN_CLEAR:   d = '0;
            FUN_INC:     d = Q + WIDTH'(1);
            FUN_DEC:     d = Q - WIDTH'(1);
            FUN_LOAD_ZX: d = {{(WIDTH-16){1'b0}}, I[15:0]};
            FUN_LOAD_SX: d = {{(WIDTH-16){I[15]}}, I[15:0]};
            FUN_LOAD_LB: d = {Q[WIDTH-1:8], I[7:0]};
            default:     d = Q;
         endcase
      end
   end

   // State register; Reset low clears at once and blocks all edge updates.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) Q <= '0;
      else        Q <= d;
   end

endmodule

// File: rtl/register_file.sv
// Register file: R1..R4 general and S1..S4 scratch registers with two read ports.
// Latency: writes take effect on the Clock edge; reads are combinational (no bypass).
// Backpressure: none; OutSel codes assume NREG = 4 (3-bit select spans 2*NREG registers).
module register_file
   import register_file_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NREG  = 4
) (
   input  logic Clock,
   input  logic Reset,
   register_file_if.slave bus
);

   // Index 0..NREG-1 = R1..R4, NREG..2*NREG-1 = S1..S4, matching the OutSel encoding.
   logic [WIDTH-1:0] reg_q [2*NREG];

   for (genvar g = 0; g < NREG; g++) begin : g_regs
      // Select bit NREG-1 enables R1/S1, bit 0 enables R4/S4.
      register32 #(.WIDTH(WIDTH)) u_gen (
         .Clock  (Clock),
         .Reset  (Reset),
         .En     (bus.RegSel[NREG-1-g]),
         .FunSel (bus.FunSel),
         .I      (bus.I),
         .Q      (reg_q[g])
      );

      register32 #(.WIDTH(WIDTH)) u_scr (
         .Clock  (Clock),
         .Reset  (Reset),
         .En     (bus.ScrSel[NREG-1-g]),
         .FunSel (bus.FunSel),
         .I      (bus.I),
         .Q      (reg_q[NREG+g])
      );
   end

   // Two independent 8:1 read muxes straight off the register outputs.
   always_comb begin
      bus.OutA = '0;
      bus.OutB = '0;
      for (int k = 0; k < 2*NREG; k++) begin
         if (bus.OutASel == SEL_W'(k)) bus.OutA = reg_q[k];
         if (bus.OutBSel == SEL_W'(k)) bus.OutB = reg_q[k];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios followed by random operations against a reference model.
// Latency: model updates on each clock edge; reads compared combinationally.
// Backpressure: none.
module tb_register_file;
   import register_file_pkg::*;

   logic Clock;
   logic Reset;
   int   checks = 0;
   int   errors = 0;

   // Reference contents: index 0..3 = R1..R4, 4..7 = S1..S4.
   logic [31:0] m [8];

   register_file_if #(.WIDTH(32), .NREG(4)) bus ();

   register_file #(.WIDTH(32), .NREG(4)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] apply(logic [2:0] f, logic [31:0] v, logic [31:0] d);
      logic [31:0] r;
      case (f)
         3'd0: r = v;
         3'd1: r = d;
         3'd2: r = 32'd0;
         3'd3: r = v + 32'd1;
         3'd4: r = v - 32'd1;
         3'd5: r = d & 32'h0000FFFF;
         3'd6: r = d[15] ? (d | 32'hFFFF0000) : (d & 32'h0000FFFF);
         default: r = (v & 32'hFFFFFF00) | (d & 32'h000000FF);
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge: model follows the operation, then enables are dropped.
   task automatic tick();
      if (Reset) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.RegSel[3-i]) m[i]   = apply(bus.FunSel, m[i],   bus.I);
            if (bus.ScrSel[3-i]) m[4+i] = apply(bus.FunSel, m[4+i], bus.I);
         end
      end
      @(posedge Clock);
      #1;
      bus.RegSel = '0;
      bus.ScrSel = '0;
   endtask

   task automatic read(input string tag, input int a, input int b);
      bus.OutASel = 3'(a);
      bus.OutBSel = 3'(b);
      #1;
      check($sformatf("%s_A%0d", tag, a), bus.OutA, m[a]);
      check($sformatf("%s_B%0d", tag, b), bus.OutB, m[b]);
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 8; k++) read(tag, k, 7 - k);
   endtask

   task automatic op(input logic [3:0] rs, input logic [3:0] ss, input logic [2:0] f, input logic [31:0] d);
      @(negedge Clock);
      bus.RegSel = rs;
      bus.ScrSel = ss;
      bus.FunSel = f;
      bus.I      = d;
      tick();
   endtask

   initial begin
      logic [3:0]  rs, ss;
      logic [2:0]  f, sa, sb;
      logic [31:0] d, pa, pb;

      for (int k = 0; k < 8; k++) m[k] = 32'd0;
      Reset       = 1'b0;
      bus.I       = '0;
      bus.RegSel  = '0;
      bus.ScrSel  = '0;
      bus.FunSel  = FUN_HOLD;
      bus.OutASel = SEL_R1;
      bus.OutBSel = SEL_S4;

      // Reset clears everything, then release away from an edge.
      #2;
      read("rst_low", 0, 7);
      @(negedge Clock);
      Reset = 1'b1;
      read("rst_rel", 0, 7);

      // Load R1 and confirm nothing else moved.
      op(4'b1000, 4'b0000, FUN_LOAD, 32'h1234ABCD);
      check_all("load_r1");

      // R2 increment wraps to zero, decrement wraps to all-ones.
      op(4'b0100, 4'b0000, FUN_LOAD, 32'hFFFFFFFF);
      op(4'b0100, 4'b0000, FUN_INC, 32'h0);
      read("inc_wrap", 1, 1);
      check("inc_wrap_const", m[1], 32'h00000000);
      op(4'b0100, 4'b0000, FUN_DEC, 32'h0);
      read("dec_wrap", 1, 1);

      // Extension and low-byte loads.
      op(4'b0000, 4'b1000, FUN_LOAD_SX, 32'h00008001);
      op(4'b0000, 4'b0100, FUN_LOAD_ZX, 32'h00008001);
      bus.OutASel = SEL_S1;
      bus.OutBSel = SEL_S2;
      #1;
      check("sx_s1", bus.OutA, 32'hFFFF8001);
      check("zx_s2", bus.OutB, 32'h00008001);
      op(4'b0010, 4'b0000, FUN_LOAD, 32'hAABBCCDD);
      op(4'b0010, 4'b0000, FUN_LOAD_LB, 32'h00000011);
      bus.OutASel = SEL_R3;
      #1;
      check("lowbyte_r3", bus.OutA, 32'hAABBCC11);

      // Load all eight distinct values, then hold-with-enable and clear-all.
      for (int k = 0; k < 4; k++) begin
         op(4'b1000 >> k, 4'b0000, FUN_LOAD, 32'h10000001 * (k + 1));
         op(4'b0000, 4'b1000 >> k, FUN_LOAD, 32'hA0000005 + k);
      end
      check_all("load_all");
      op(4'b1111, 4'b1111, FUN_HOLD, 32'hDEADBEEF);
      check_all("hold_all");
      op(4'b1111, 4'b1111, FUN_CLEAR, 32'hDEADBEEF);
      check_all("clear_all");

      // Read during a pending write returns the pre-edge value.
      @(negedge Clock);
      bus.RegSel  = 4'b0001;
      bus.FunSel  = FUN_LOAD;
      bus.I       = 32'h5A5A5A5A;
      bus.OutASel = SEL_R4;
      bus.OutBSel = SEL_R4;
      #1;
      check("prewrite_A", bus.OutA, 32'h0);
      check("prewrite_B", bus.OutB, 32'h0);
      tick();
      read("postwrite", 3, 3);

      // Reset mid-increment overrides, holds through edges, then normal operation resumes.
      op(4'b1000, 4'b0000, FUN_LOAD, 32'd5);
      @(negedge Clock);
      bus.RegSel  = 4'b1000;
      bus.FunSel  = FUN_INC;
      bus.OutASel = SEL_R1;
      Reset = 1'b0;
      for (int k = 0; k < 8; k++) m[k] = 32'd0;
      #1;
      check("rst_mid_A", bus.OutA, 32'd0);
      repeat (2) @(posedge Clock);
      #1;
      check("rst_hold_A", bus.OutA, 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      tick();
      bus.OutASel = SEL_R1;
      #1;
      check("rst_first_inc", bus.OutA, 32'd1);
      check_all("after_rst");

      // Random operations, checking pre-edge and post-edge reads.
      for (int n = 0; n < 200; n++) begin
         rs = 4'($urandom);
         ss = 4'($urandom);
         f  = 3'($urandom);
         sa = 3'($urandom);
         sb = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       d = 32'hFFFFFFFF;
            1:       d = 32'($urandom_range(0, 3));
            default: d = $urandom;
         endcase
         @(negedge Clock);
         bus.RegSel  = rs;
         bus.ScrSel  = ss;
         bus.FunSel  = f;
         bus.I       = d;
         bus.OutASel = sa;
         bus.OutBSel = sb;
         #1;
         pa = m[sa];
         pb = m[sb];
         check($sformatf("rnd%0d_pre_A", n), bus.OutA, pa);
         check($sformatf("rnd%0d_pre_B", n), bus.OutB, pb);
         tick();
         read($sformatf("rnd%0d_post", n), int'(sa), int'(sb));
      end
      check_all("rnd_final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
